// File: rtl/oven_pkg.sv
// -----------------------------------------------------------------------------
// oven_pkg
// Shared types and defaults for the oven front-panel controller and the
// seven-segment display block that consumes its outputs.
//   - TEMP_W / TIME_W : widths of the temperature and seconds values
//   - oven_state_t    : controller state encoding (3 bits)
//   - DEF_*           : default parameter values for oven_controller
//   - step_clamp()    : saturating +/- step, evaluated one bit wider than
//                       the widest value so nothing can wrap
// -----------------------------------------------------------------------------
package oven_pkg;

    localparam int TEMP_W = 10;
    localparam int TIME_W = 13;

    typedef logic [TEMP_W-1:0] temp_t;
    typedef logic [TIME_W-1:0] time_t;
    // Working width for all clamping arithmetic (covers both temp and time).
    typedef logic [TIME_W:0]   wide_t;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_SET_TEMP = 3'd1,
        ST_SET_TIME = 3'd2,
        ST_PREHEAT  = 3'd3,
        ST_COOK     = 3'd4,
        ST_DONE     = 3'd5
    } oven_state_t;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_AMBIENT      = 70;
    localparam int DEF_TEMP_MIN     = 150;
    localparam int DEF_TEMP_MAX     = 500;
    localparam int DEF_TEMP_STEP    = 5;
    localparam int DEF_TEMP_DEFAULT = 350;
    localparam int DEF_TIME_STEP    = 10;
    localparam int DEF_TIME_MAX     = 5990;
    localparam int DEF_HEAT_RATE    = 5;
    localparam int DEF_COOL_RATE    = 1;
    localparam int DEF_HYST         = 5;

    // Step value up (capped at hi) or down (floored at lo).
    function automatic wide_t step_clamp(input wide_t value, input wide_t step,
                                         input wide_t lo, input wide_t hi,
                                         input logic up);
        wide_t sum;
        sum = value + step;
        if (up)
            return (sum > hi) ? hi : sum;
        else
            return (value < lo + step) ? lo : value - step;
    endfunction

endpackage

// File: rtl/oven_if.sv
// -----------------------------------------------------------------------------
// oven_if
// Front-panel bundle: switch/button levels into the controller and the
// registered status/value outputs toward the display and heater logic.
//   master : panel side (drives switch and buttons, observes status)
//   slave  : oven_controller side
// -----------------------------------------------------------------------------
interface oven_if;
    import oven_pkg::*;

    logic  powerSw;
    logic  incBtn;
    logic  decBtn;
    logic  enterBtn;
    logic  cancelBtn;

    logic  power;
    logic  tempInputDone;
    logic  timeInputDone;
    temp_t current_temp;
    temp_t target_temp;
    time_t current_time;
    time_t target_time;
    logic  heaterOn;
    logic  doneAlarm;

    modport master (
        output powerSw, incBtn, decBtn, enterBtn, cancelBtn,
        input  power, tempInputDone, timeInputDone, current_temp, target_temp,
               current_time, target_time, heaterOn, doneAlarm
    );

    modport slave (
        input  powerSw, incBtn, decBtn, enterBtn, cancelBtn,
        output power, tempInputDone, timeInputDone, current_temp, target_temp,
               current_time, target_time, heaterOn, doneAlarm
    );

endinterface

// File: rtl/oven_tick_gen.sv
// -----------------------------------------------------------------------------
// oven_tick_gen
// One-second prescaler: counts 0..CLK_HZ-1 and pulses tick for one cycle
// when the count wraps.
//   clk, resetn : clock, asynchronous active-low reset
//   clr         : restart the count at 0 on the next edge (no tick that cycle)
//   tick        : one-cycle pulse every CLK_HZ cycles
// -----------------------------------------------------------------------------
module oven_tick_gen #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Clearing at the enter edge makes the first tick land exactly CLK_HZ
    // cycles later.
    assign tick = (cnt_reg == CNT_LAST) && !clr;

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        if (clr || tick)
            cnt_next = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_next;
    end

endmodule

// File: rtl/oven_controller.sv
// -----------------------------------------------------------------------------
// oven_controller
// Oven front-panel sequencer: OFF -> SET_TEMP -> SET_TIME -> PREHEAT -> COOK
// -> DONE, with a simple thermal model and bang-bang heater control.
//   clk, resetn : clock, asynchronous active-low reset
//   panel       : oven_if.slave -- powerSw and inc/dec/enter/cancel levels in;
//                 power, tempInputDone, timeInputDone, current_temp,
//                 target_temp, current_time, target_time, heaterOn,
//                 doneAlarm out (all registered)
// -----------------------------------------------------------------------------
module oven_controller
    import oven_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int AMBIENT      = DEF_AMBIENT,
    parameter int TEMP_MIN     = DEF_TEMP_MIN,
    parameter int TEMP_MAX     = DEF_TEMP_MAX,
    parameter int TEMP_STEP    = DEF_TEMP_STEP,
    parameter int TEMP_DEFAULT = DEF_TEMP_DEFAULT,
    parameter int TIME_STEP    = DEF_TIME_STEP,
    parameter int TIME_MAX     = DEF_TIME_MAX,
    parameter int HEAT_RATE    = DEF_HEAT_RATE,
    parameter int COOL_RATE    = DEF_COOL_RATE,
    parameter int HYST         = DEF_HYST
) (
    input  logic  clk,
    input  logic  resetn,
    oven_if.slave panel
);

    localparam wide_t W_AMBIENT   = wide_t'(AMBIENT);
    localparam wide_t W_TEMP_MIN  = wide_t'(TEMP_MIN);
    localparam wide_t W_TEMP_MAX  = wide_t'(TEMP_MAX);
    localparam wide_t W_TEMP_STEP = wide_t'(TEMP_STEP);
    localparam wide_t W_TIME_STEP = wide_t'(TIME_STEP);
    localparam wide_t W_TIME_MAX  = wide_t'(TIME_MAX);
    localparam wide_t W_HEAT      = wide_t'(HEAT_RATE);
    localparam wide_t W_COOL      = wide_t'(COOL_RATE);
    localparam wide_t W_HYST      = wide_t'(HYST);

    oven_state_t state_reg, state_next;

    // Button order in these vectors: {inc, dec, enter, cancel}
    logic [3:0] btn_level, btn_prev_reg, btn_event;
    logic       inc_ev, dec_ev, enter_ev, cancel_ev;
    logic       tick, start_cook;

    temp_t current_temp_reg, current_temp_next;
    temp_t target_temp_reg,  target_temp_next;
    time_t current_time_reg, current_time_next;
    time_t target_time_reg,  target_time_next;
    logic  power_reg,     power_next;
    logic  temp_done_reg, temp_done_next;
    logic  time_done_reg, time_done_next;
    logic  heater_reg,    heater_next;
    logic  alarm_reg,     alarm_next;

    wide_t cur_w, tgt_w, tim_w;

    assign btn_level = {panel.incBtn, panel.decBtn, panel.enterBtn, panel.cancelBtn};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_edge
            assign btn_event[gi] = btn_level[gi] & ~btn_prev_reg[gi];
        end
    endgenerate

    // inc and dec together cancel each other out.
    assign inc_ev    = btn_event[3] & ~btn_event[2];
    assign dec_ev    = btn_event[2] & ~btn_event[3];
    assign enter_ev  = btn_event[1];
    assign cancel_ev = btn_event[0];

    assign cur_w = wide_t'(current_temp_reg);
    assign tgt_w = wide_t'(target_temp_reg);
    assign tim_w = wide_t'(target_time_reg);

    assign start_cook = (state_reg == ST_SET_TIME) && (state_next == ST_PREHEAT);

    oven_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk    (clk),
        .resetn (resetn),
        .clr    (start_cook),
        .tick   (tick)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state_reg <= ST_OFF;
        else
            state_reg <= state_next;
    end

    // Next-state logic; the power switch dominates everything.
    always_comb begin
        state_next = state_reg;
        if (!panel.powerSw) begin
            state_next = ST_OFF;
        end else begin
            case (state_reg)
                ST_OFF:      state_next = ST_SET_TEMP;
                ST_SET_TEMP: if (enter_ev) state_next = ST_SET_TIME;
                ST_SET_TIME: begin
                    if (cancel_ev)
                        state_next = ST_SET_TEMP;
                    else if (enter_ev && target_time_reg != '0)
                        state_next = ST_PREHEAT;
                end
                ST_PREHEAT: begin
                    if (cancel_ev)
                        state_next = ST_SET_TEMP;
                    else if (current_temp_reg >= target_temp_reg)
                        state_next = ST_COOK;
                end
                ST_COOK: begin
                    if (cancel_ev)
                        state_next = ST_SET_TEMP;
                    else if (tick && current_time_reg == time_t'(1))
                        state_next = ST_DONE;
                end
                ST_DONE:     if (enter_ev || cancel_ev) state_next = ST_SET_TEMP;
                default:     state_next = ST_OFF;
            endcase
        end
    end

    // Output / datapath next values. Flags and heater follow the state being
    // entered, so they change on the same edge as the state itself.
    always_comb begin
        current_temp_next = current_temp_reg;
        target_temp_next  = target_temp_reg;
        current_time_next = current_time_reg;
        target_time_next  = target_time_reg;

        // Thermal model: heat only while actively preheating or when the
        // heater is driving in COOK, otherwise drift down toward ambient.
        if (tick) begin
            if (state_reg == ST_PREHEAT && cur_w < tgt_w)
                current_temp_next = temp_t'(step_clamp(cur_w, W_HEAT, '0, tgt_w, 1'b1));
            else if (state_reg == ST_COOK && heater_reg)
                current_temp_next = temp_t'(step_clamp(cur_w, W_HEAT, '0, W_TEMP_MAX, 1'b1));
            else
                current_temp_next = temp_t'(step_clamp(cur_w, W_COOL, W_AMBIENT, W_AMBIENT, 1'b0));
        end

        if (panel.powerSw && state_reg == ST_SET_TEMP) begin
            if (inc_ev)
                target_temp_next = temp_t'(step_clamp(tgt_w, W_TEMP_STEP, W_TEMP_MIN, W_TEMP_MAX, 1'b1));
            else if (dec_ev)
                target_temp_next = temp_t'(step_clamp(tgt_w, W_TEMP_STEP, W_TEMP_MIN, W_TEMP_MAX, 1'b0));
        end

        if (panel.powerSw && state_reg == ST_SET_TIME) begin
            if (inc_ev)
                target_time_next = time_t'(step_clamp(tim_w, W_TIME_STEP, '0, W_TIME_MAX, 1'b1));
            else if (dec_ev)
                target_time_next = time_t'(step_clamp(tim_w, W_TIME_STEP, '0, W_TIME_MAX, 1'b0));
        end

        // Countdown; later assignments take precedence.
        if (state_reg == ST_COOK && tick && current_time_reg != '0)
            current_time_next = current_time_reg - 1'b1;
        if (start_cook)
            current_time_next = target_time_reg;
        if (state_next == ST_OFF || state_next == ST_SET_TEMP)
            current_time_next = '0;

        power_next     = (state_next != ST_OFF);
        temp_done_next = (state_next == ST_SET_TIME) || (state_next == ST_PREHEAT) ||
                         (state_next == ST_COOK)     || (state_next == ST_DONE);
        time_done_next = (state_next == ST_PREHEAT) || (state_next == ST_COOK) ||
                         (state_next == ST_DONE);
        alarm_next     = (state_next == ST_DONE);

        // Bang-bang with a band: on below target-HYST, off at target,
        // otherwise keep the previous drive.
        heater_next = 1'b0;
        if (state_next == ST_PREHEAT) begin
            heater_next = 1'b1;
        end else if (state_next == ST_COOK) begin
            if (cur_w >= tgt_w)
                heater_next = 1'b0;
            else if (cur_w + W_HYST < tgt_w)
                heater_next = 1'b1;
            else
                heater_next = heater_reg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            btn_prev_reg     <= '0;
            current_temp_reg <= temp_t'(AMBIENT);
            target_temp_reg  <= temp_t'(TEMP_DEFAULT);
            current_time_reg <= '0;
            target_time_reg  <= '0;
            power_reg        <= 1'b0;
            temp_done_reg    <= 1'b0;
            time_done_reg    <= 1'b0;
            heater_reg       <= 1'b0;
            alarm_reg        <= 1'b0;
        end else begin
            btn_prev_reg     <= btn_level;
            current_temp_reg <= current_temp_next;
            target_temp_reg  <= target_temp_next;
            current_time_reg <= current_time_next;
            target_time_reg  <= target_time_next;
            power_reg        <= power_next;
            temp_done_reg    <= temp_done_next;
            time_done_reg    <= time_done_next;
            heater_reg       <= heater_next;
            alarm_reg        <= alarm_next;
        end
    end

    assign panel.power         = power_reg;
    assign panel.tempInputDone = temp_done_reg;
    assign panel.timeInputDone = time_done_reg;
    assign panel.current_temp  = current_temp_reg;
    assign panel.target_temp   = target_temp_reg;
    assign panel.current_time  = current_time_reg;
    assign panel.target_time   = target_time_reg;
    assign panel.heaterOn      = heater_reg;
    assign panel.doneAlarm     = alarm_reg;

endmodule

// File: tb/tb_oven_controller.sv
// -----------------------------------------------------------------------------
// tb_oven_controller
// Directed bench for oven_controller with CLK_HZ=4: setpoint entry, clamping,
// button edge detection, preheat/cook timing, bang-bang heater, done, cancel,
// power-off and asynchronous reset mid-cook.
// -----------------------------------------------------------------------------
module tb_oven_controller;
    import oven_pkg::*;

    localparam logic [3:0] B_INC = 4'b1000;
    localparam logic [3:0] B_DEC = 4'b0100;
    localparam logic [3:0] B_ENT = 4'b0010;
    localparam logic [3:0] B_CAN = 4'b0001;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    oven_if panel_if ();

    oven_controller #(.CLK_HZ(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .panel  (panel_if)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("check %s got=%0d ok", tag, got);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [3:0] mask);
        {panel_if.incBtn, panel_if.decBtn, panel_if.enterBtn, panel_if.cancelBtn} = mask;
    endtask

    // One event: buttons high for one edge, then released for one edge.
    task automatic press(input logic [3:0] mask);
        set_btns(mask);
        step(1);
        set_btns(4'b0000);
        step(1);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, "_power"},     32'(panel_if.power),         0);
        check_val({tag, "_tempdone"},  32'(panel_if.tempInputDone), 0);
        check_val({tag, "_timedone"},  32'(panel_if.timeInputDone), 0);
        check_val({tag, "_cur_temp"},  32'(panel_if.current_temp),  70);
        check_val({tag, "_tgt_temp"},  32'(panel_if.target_temp),   350);
        check_val({tag, "_cur_time"},  32'(panel_if.current_time),  0);
        check_val({tag, "_tgt_time"},  32'(panel_if.target_time),   0);
        check_val({tag, "_heater"},    32'(panel_if.heaterOn),      0);
        check_val({tag, "_alarm"},     32'(panel_if.doneAlarm),     0);
    endtask

    // From SET_TEMP with a nonzero target time: enter, enter, then wait for
    // the heater to drop, which happens only on reaching COOK.
    task automatic run_to_cook(input string tag);
        int n;
        press(B_ENT);
        press(B_ENT);
        check_val({tag, "_preheat_time"}, 32'(panel_if.current_time), 20);
        n = 0;
        while (panel_if.heaterOn === 1'b1 && n < 400) begin
            step(1);
            n++;
        end
        check_val({tag, "_cook_entry_heater"}, 32'(panel_if.heaterOn), 0);
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        panel_if.powerSw = 1'b0;
        set_btns(4'b0000);
        step(3);
        check_reset_state("reset");

        resetn = 1'b1;
        step(2);
        check_val("off_power", 32'(panel_if.power), 0);
        panel_if.powerSw = 1'b1;
        step(1);
        check_val("on_power", 32'(panel_if.power), 1);

        // Setpoint entry and edge detection
        for (int i = 0; i < 3; i++) press(B_INC);
        check_val("inc3_temp", 32'(panel_if.target_temp), 365);
        set_btns(B_INC);
        step(10);
        set_btns(4'b0000);
        step(1);
        check_val("hold_inc_temp", 32'(panel_if.target_temp), 370);
        for (int i = 0; i < 50; i++) press(B_DEC);
        check_val("dec_clamp_temp", 32'(panel_if.target_temp), 150);
        press(B_INC | B_DEC);
        check_val("incdec_temp", 32'(panel_if.target_temp), 150);
        check_val("settemp_tempdone", 32'(panel_if.tempInputDone), 0);

        // Time entry
        press(B_ENT);
        check_val("settime_tempdone", 32'(panel_if.tempInputDone), 1);
        check_val("settime_timedone", 32'(panel_if.timeInputDone), 0);
        press(B_DEC);
        check_val("dec_floor_time", 32'(panel_if.target_time), 0);
        press(B_ENT);
        check_val("zero_enter_timedone", 32'(panel_if.timeInputDone), 0);
        check_val("zero_enter_heater", 32'(panel_if.heaterOn), 0);
        press(B_INC);
        press(B_INC);
        check_val("inc2_time", 32'(panel_if.target_time), 20);

        // Enter at edge k; timings below are relative to k.
        set_btns(B_ENT);
        step(1);
        set_btns(4'b0000);
        check_val("k0_timedone", 32'(panel_if.timeInputDone), 1);
        check_val("k0_cur_time", 32'(panel_if.current_time), 20);
        check_val("k0_heater", 32'(panel_if.heaterOn), 1);
        check_val("k0_cur_temp", 32'(panel_if.current_temp), 70);
        step(63);   // k+63: 15 ticks
        check_val("k63_cur_temp", 32'(panel_if.current_temp), 145);
        check_val("k63_cur_time", 32'(panel_if.current_time), 20);
        check_val("k63_heater", 32'(panel_if.heaterOn), 1);
        step(1);    // k+64: 16th tick
        check_val("k64_cur_temp", 32'(panel_if.current_temp), 150);
        check_val("k64_heater", 32'(panel_if.heaterOn), 1);
        step(1);    // k+65: COOK, at target so heater off
        check_val("k65_heater", 32'(panel_if.heaterOn), 0);
        check_val("k65_cur_time", 32'(panel_if.current_time), 20);
        step(21);   // k+86: cooled 5 ticks, inside band
        check_val("k86_cur_temp", 32'(panel_if.current_temp), 145);
        check_val("k86_heater", 32'(panel_if.heaterOn), 0);
        step(4);    // k+90: 144 < 145, heater back on
        check_val("k90_cur_temp", 32'(panel_if.current_temp), 144);
        check_val("k90_heater", 32'(panel_if.heaterOn), 1);
        check_val("k90_cur_time", 32'(panel_if.current_time), 14);
        step(53);   // k+143
        check_val("k143_cur_time", 32'(panel_if.current_time), 1);
        check_val("k143_alarm", 32'(panel_if.doneAlarm), 0);
        step(1);    // k+144: 20th cook tick
        check_val("k144_cur_time", 32'(panel_if.current_time), 0);
        check_val("k144_alarm", 32'(panel_if.doneAlarm), 1);
        check_val("k144_heater", 32'(panel_if.heaterOn), 0);

        // DONE -> SET_TEMP
        press(B_ENT);
        check_val("done_exit_alarm", 32'(panel_if.doneAlarm), 0);
        check_val("done_exit_tempdone", 32'(panel_if.tempInputDone), 0);
        check_val("done_exit_timedone", 32'(panel_if.timeInputDone), 0);
        check_val("done_exit_tgt_time", 32'(panel_if.target_time), 20);

        // Cancel together with enter in COOK
        run_to_cook("c2");
        step(4);
        press(B_CAN | B_ENT);
        check_val("cancel_tempdone", 32'(panel_if.tempInputDone), 0);
        check_val("cancel_timedone", 32'(panel_if.timeInputDone), 0);
        check_val("cancel_heater", 32'(panel_if.heaterOn), 0);
        check_val("cancel_cur_time", 32'(panel_if.current_time), 0);
        press(B_INC);
        check_val("cancel_settemp_inc", 32'(panel_if.target_temp), 155);
        check_val("cancel_tgt_time", 32'(panel_if.target_time), 20);

        // Power off in COOK
        run_to_cook("c3");
        step(6);
        panel_if.powerSw = 1'b0;
        step(1);
        check_val("pwroff_power", 32'(panel_if.power), 0);
        check_val("pwroff_cur_time", 32'(panel_if.current_time), 0);
        check_val("pwroff_heater", 32'(panel_if.heaterOn), 0);
        check_val("pwroff_tgt_temp", 32'(panel_if.target_temp), 155);
        check_val("pwroff_tgt_time", 32'(panel_if.target_time), 20);
        panel_if.powerSw = 1'b1;
        step(1);
        check_val("pwron_power", 32'(panel_if.power), 1);

        // Asynchronous reset at cook tick 5
        run_to_cook("c4");
        n = 0;
        while (panel_if.current_time !== 13'd15 && n < 100) begin
            step(1);
            n++;
        end
        check_val("c4_tick5_time", 32'(panel_if.current_time), 15);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_state("async_rst");
        step(2);
        resetn = 1'b1;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
